// File: rtl/serial_shifter_unit_pkg.sv
// Shared definitions for the iterative shifter: op/state encodings and datapath widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package shifter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_PASS = 2'b10,
    OP_SRA  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Bits to move this cycle: the per-cycle step, or whatever remains if less.
  function automatic logic [SHAMT_W-1:0] step_amount(input logic [SHAMT_W-1:0] count,
                                                     input logic [SHAMT_W-1:0] step);
    return (count < step) ? count : step;
  endfunction

endpackage

// File: rtl/serial_shifter_unit_if.sv
// Request/result bundle between the operand muxes and the shifter.
// Latency: n/a (wiring only).
// Backpressure: requester may only present start when ready=1; extra starts are dropped.
// Signals: start/op/shamt/In driven by the master; ready/busy/done/Out driven by the slave.
interface serial_shifter_unit_if;
  import shifter_pkg::*;

  logic               start;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   In;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   Out;

  modport master (
    output start, op, shamt, In,
    input  ready, busy, done, Out
  );

  modport slave (
    input  start, op, shamt, In,
    output ready, busy, done, Out
  );

endinterface

// File: rtl/serial_shifter_unit_shift_step.sv
// Combinational single-step shifter: moves i_data by i_k positions according to i_op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_data operand, i_op shift kind, i_k distance, o_data shifted result.
module shift_step
  import shifter_pkg::*;
(
  input  logic [WIDTH-1:0]   i_data,
  input  op_e                i_op,
  input  logic [SHAMT_W-1:0] i_k,
  output logic [WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SLL:  o_data = i_data << i_k;
      OP_SRL:  o_data = i_data >> i_k;
      // Arithmetic shift replicates bit 31, so the sign survives every partial step.
      OP_SRA:  o_data = WIDTH'($signed(i_data) >>> i_k);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/serial_shifter_unit.sv
// Iterative RV32I shifter (SLL/SRL/SRA/PASS), STEP bit positions per cycle.
// Latency: 1 + ceil(shamt/STEP) cycles from accept to the done pulse; 1 for shamt=0 or PASS.
// Backpressure: ready only in IDLE; start while busy is ignored, no queuing.
// Ports: clk, rst (async, active-high), bus (slave side of serial_shifter_unit_if).
module serial_shifter_unit
  import shifter_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_shifter_unit_if.slave  bus
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
      $error("serial_shifter_unit: STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_e             r_state, w_state_nxt;
  logic [SHAMT_W-1:0] r_count, w_count_nxt;
  op_e                r_op, w_op_nxt;
  logic [WIDTH-1:0]   r_out, w_out_nxt;
  logic               r_done;
  logic [SHAMT_W-1:0] w_k;
  logic [WIDTH-1:0]   w_shifted;

  assign w_k = step_amount(r_count, STEP_K);

  shift_step u_shift_step (
    .i_data (r_out),
    .i_op   (r_op),
    .i_k    (w_k),
    .o_data (w_shifted)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_out_nxt   = bus.In;
          w_count_nxt = bus.shamt;
          w_op_nxt    = op_e'(bus.op);
          // Nothing to shift: go straight to the result cycle.
          if (bus.shamt == '0 || bus.op == OP_PASS) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_out_nxt   = w_shifted;
        w_count_nxt = r_count - w_k;
        if (r_count == w_k) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= OP_SLL;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      r_out   <= w_out_nxt;
      // Registered copy of "in DONE" so done comes straight from a flop.
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.ready = (r_state == S_IDLE);
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = r_done;
  assign bus.Out   = r_out;

endmodule

// File: tb/tb_serial_shifter_unit.sv
// Bench: STEP=1 and STEP=4 shifters share one request stream; a scoreboard per unit
// holds expected result and latency, popped when that unit pulses done.
// Covers reset state, directed corner cases, ignored starts, mid-op reset and random ops.
module tb_serial_shifter_unit;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_start;
  logic [1:0]  r_op;
  logic [4:0]  r_shamt;
  logic [31:0] r_in;

  always #5 clk = ~clk;

  serial_shifter_unit_if if1 ();
  serial_shifter_unit_if if4 ();

  assign if1.start = r_start;
  assign if1.op    = r_op;
  assign if1.shamt = r_shamt;
  assign if1.In    = r_in;
  assign if4.start = r_start;
  assign if4.op    = r_op;
  assign if4.shamt = r_shamt;
  assign if4.In    = r_in;

  serial_shifter_unit #(.STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_shifter_unit #(.STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] lat;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;

  int c1 = 0, c4 = 0;
  bit f1 = 0, f4 = 0, p1 = 0, p4 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] s,
                                        input logic [31:0] d);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b11:   return 32'(sd >>> s);
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] lat_of(input logic [1:0] o, input logic [4:0] s,
                                         input int step);
    if (o == 2'b10 || s == 5'd0) return 32'd1;
    return 32'(1 + (int'(s) + step - 1) / step);
  endfunction

  // One negedge of monitoring for one unit; sel picks its scoreboard.
  task automatic mon_step(input string nm, input int sel, input logic done,
                          input logic ready, input logic busy, input logic [31:0] out,
                          inout int c, inout bit inflight, inout bit post);
    exp_t e;
    if (post) begin
      check({nm, "_ready_after_done"}, 32'(ready), 32'd1);
      post = 0;
    end
    if (inflight) begin
      c++;
      if (done) begin
        check({nm, "_sb_nonempty"}, 32'((sel == 1) ? (q1.size() != 0) : (q4.size() != 0)), 32'd1);
        if (sel == 1 && q1.size() != 0) e = q1.pop_front();
        else if (sel == 4 && q4.size() != 0) e = q4.pop_front();
        else e = '0;
        check({nm, "_out"}, out, e.res);
        check({nm, "_latency"}, 32'(c), e.lat);
        check({nm, "_busy_in_done"}, 32'(busy), 32'd1);
        inflight = 0;
        post = 1;
      end else if (c > 200) begin
        check({nm, "_done_within_budget"}, 32'(c), 32'd200);
        inflight = 0;
      end
    end else if (done) begin
      check({nm, "_spurious_done"}, 32'(done), 32'd0);
    end
    if (r_start && ready) begin
      inflight = 1;
      c = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        f1 = 0; p1 = 0; f4 = 0; p4 = 0;
      end else begin
        mon_step("s1", 1, if1.done, if1.ready, if1.busy, if1.Out, c1, f1, p1);
        mon_step("s4", 4, if4.done, if4.ready, if4.busy, if4.Out, c4, f4, p4);
      end
    end
  end

  // Entered and left at posedge+#1.
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    int n = 0;
    while (!(if1.ready && if4.ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("ready_wait_timeout", 32'(n), 32'd0);
    q1.push_back('{res: model(o, s, d), lat: lat_of(o, s, 1)});
    q4.push_back('{res: model(o, s, d), lat: lat_of(o, s, 4)});
    r_start = 1'b1;
    r_op    = o;
    r_shamt = s;
    r_in    = d;
    @(posedge clk); #1;
    // Scramble the operands after accept; the units must use only captured values.
    r_start = 1'b0;
    r_op    = 2'($urandom);
    r_shamt = 5'($urandom);
    r_in    = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(n), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    r_start = 1'b0;
    r_op    = 2'b00;
    r_shamt = 5'd0;
    r_in    = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out1",   if1.Out, 32'd0);
    check("rst_out4",   if4.Out, 32'd0);
    check("rst_ready1", 32'(if1.ready), 32'd1);
    check("rst_ready4", 32'(if4.ready), 32'd1);
    check("rst_busy1",  32'(if1.busy), 32'd0);
    check("rst_done1",  32'(if1.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(2'b00, 5'd31, 32'h0000_0001);
    issue(2'b11, 5'd4,  32'h8000_0000);
    issue(2'b01, 5'd4,  32'h8000_0000);
    issue(2'b00, 5'd0,  32'hDEAD_BEEF);
    issue(2'b10, 5'd9,  32'h1234_5678);
    issue(2'b01, 5'd7,  32'hFFFF_FFFF);
    drain();

    // start pulsed while both units are shifting must be dropped.
    issue(2'b00, 5'd20, 32'h0000_0003);
    r_start = 1'b1;
    r_op    = 2'b01;
    r_shamt = 5'd2;
    r_in    = 32'hA5A5_A5A5;
    repeat (2) begin @(posedge clk); #1; end
    r_start = 1'b0;
    drain();

    // Reset in the middle of a long shift: no done, Out cleared, ready back.
    issue(2'b01, 5'd20, 32'hFFFF_0000);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    q1.delete();
    q4.delete();
    @(negedge clk);
    check("midrst_out1",  if1.Out, 32'd0);
    check("midrst_out4",  if4.Out, 32'd0);
    check("midrst_done1", 32'(if1.done), 32'd0);
    check("midrst_done4", 32'(if4.done), 32'd0);
    check("midrst_busy4", 32'(if4.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready1", 32'(if1.ready), 32'd1);
    check("postrst_ready4", 32'(if4.ready), 32'd1);
    @(posedge clk); #1;
    issue(2'b11, 5'd17, 32'h8765_4321);
    drain();

    for (int i = 0; i < 24; i++) begin
      issue(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_shifter_unit.md
Name: serial_shifter_unit

Overview:
Multi-cycle iterative shifter for the RV32I execute stage. It implements SLL/SRL/SRA (and SLLI/SRLI/SRAI) for the ALU path. It accepts an operand, a shift amount and an op code through a start/ready handshake. It shifts by STEP bit positions per cycle and presents the result with a one-cycle done pulse. It sits between the decode-driven operand muxes and the writeback mux, with a deterministic latency the pipeline control can stall on.

Parameters:
STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
WIDTH, 32, datapath width; fixed at 32 for RV32I; shamt width is log2(WIDTH) = 5.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request strobe; accepted only when ready=1
op  input  2  00=SLL, 01=SRL, 11=SRA, 10=PASS (result = In, no shift)
shamt  input  5  shift amount, sampled on accept
In  input  32  operand, sampled on accept
ready  output  1  1 in IDLE; unit can accept start
busy  output  1  1 while an operation is in flight (SHIFT or DONE)
done  output  1  single-cycle pulse; Out is valid and final this cycle
Out  output  32  result register; holds until the next accept

Behaviour:
- Reset: rst=1 forces state=IDLE, Out=0, done=0, busy=0, ready=1, internal count=0. Asserting reset mid-operation abandons the operation immediately; no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. On start=1, capture In into Out, shamt into count, op into op_q. Go to SHIFT, or directly to DONE if shamt=0 or op=PASS.
- SHIFT: each cycle, k = min(STEP, count). Apply the shift to Out:
  - SLL: Out <<= k, zero fill.
  - SRL: Out >>= k, zero fill.
  - SRA: Out >>= k, filled with Out[31] (sign bit of the captured value; it is preserved because each step replicates bit 31).
  - Then count -= k. When count reaches 0 after the update, the next state is DONE.
- DONE: done=1 for exactly one cycle, busy=1, ready=0. Next state is IDLE.
- Latency from accept edge to done cycle: 1 + ceil(shamt/STEP) cycles. For shamt=0 or PASS it is 1 cycle.
- Back-to-back throughput: next accept earliest the cycle after done (ready rises in IDLE). Total per op = latency + 1.
- start while busy=1 is ignored. No queuing, no error flag, and captured operands are unaffected.
- Input changes after accept have no effect. The unit uses only captured values.
- Out retains the last result in IDLE. Out is only modified on accept and during SHIFT.
- shamt uses only 5 bits. Shifts of 0..31 are exact; no wrap or modulo behaviour beyond the 5-bit field.
- op=10 (reserved/PASS): Out=In, done after 1 cycle. Used as a bypass path for diagnostic builds.
- All outputs are registered. No combinational path from inputs to outputs except ready/busy from state.

Decomposition:
- Shared package shifter_pkg: op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_PASS=2'b10), state encodings (S_IDLE, S_SHIFT, S_DONE), WIDTH and SHAMT_W constants.
- One sub-module, shift_step: combinational single-step shifter (inputs data, op, k; output shifted data). It is instantiated once inside the sequencer. The top holds the FSM, count and Out register.

Test Plan:
- STEP=1, SLL, In=0x00000001, shamt=31: done exactly 32 cycles after accept, Out=0x80000000; ready high the following cycle.
- STEP=1, SRA, In=0x80000000, shamt=4: done at cycle 5, Out=0xF8000000. Repeat with SRL: Out=0x08000000.
- shamt=0 (SLL, In=0xDEADBEEF) and op=PASS (shamt=9, In=0x12345678): done at cycle 1, Out equals In in both cases.
- STEP=4, SRL, In=0xFFFFFFFF, shamt=7: exactly 2 SHIFT cycles (k=4, then k=3), done at cycle 3, Out=0x01FFFFFF.
- start pulsed with different In/shamt while busy=1: ignored. The original result and latency are unchanged, and only one done pulse is issued.
- rst asserted for 1 cycle in mid-SHIFT of shamt=20: Out=0, done never asserted, ready=1 right after reset release. A new request completes correctly.
